rcc_eth_lp_seq: RTL and testbench

RCC_ETH_LP_SEQ -- requirements
Module: rcc_eth_lp_seq

---
 rtl/rcc_eth_lp_seq.sv | 157 +++++++++++++++
 tb/tb_rcc_eth_lp_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_eth_lp_seq.sv
// ETH1 RX/TX kernel clock-enable sequencer: drains the MAC before gating a clock off, delays wake-up.
// Optional drain timeout is compiled in with macro RCC_ETH_LP_TIMEOUT_EN.
module rcc_eth_lp_seq #(
    parameter int WAKE_DLY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c1_sleep,
    input  logic       c1_deepsleep,
    input  logic       c2_sleep,
    input  logic       c2_deepsleep,
    input  logic       rcc_c1_eth1rx_en,
    input  logic       rcc_c2_eth1rx_en,
    input  logic       rcc_c1_eth1rx_lpen,
    input  logic       rcc_c2_eth1rx_lpen,
    input  logic       rcc_c1_eth1tx_en,
    input  logic       rcc_c2_eth1tx_en,
    input  logic       rcc_c1_eth1tx_lpen,
    input  logic       rcc_c2_eth1tx_lpen,
    input  logic       eth_rcc_idle,
    input  logic [7:0] drain_tmo,
    input  logic       tmo_clr,
    output logic       rcc_eth1rx_clk_en,
    output logic       rcc_eth1tx_clk_en,
    output logic       rcc_eth_lp_busy,
    output logic       rcc_eth_tmo_flag
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        WAKE  = 2'd2
    } state_t;

    localparam logic [3:0] WAKE_INIT = 4'(WAKE_DLY);

    state_t     state_q, state_d;
    logic [1:0] cur_q, cur_d;
    logic [1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0] wake_cnt_q, wake_cnt_d;
    logic       busy_q, busy_d;
    logic       tmo_flag_q, tmo_flag_d;
    logic       tmo_hit;
    logic       tmo_set;
    logic       want_rx, want_tx;
    logic [1:0] want, off_pend, on_pend;

    assign want_rx = (rcc_c1_eth1rx_en & (~c1_sleep | rcc_c1_eth1rx_lpen) & ~c1_deepsleep)
                   | (rcc_c2_eth1rx_en & (~c2_sleep | rcc_c2_eth1rx_lpen) & ~c2_deepsleep);
    assign want_tx = (rcc_c1_eth1tx_en & (~c1_sleep | rcc_c1_eth1tx_lpen) & ~c1_deepsleep)
                   | (rcc_c2_eth1tx_en & (~c2_sleep | rcc_c2_eth1tx_lpen) & ~c2_deepsleep);
    assign want     = {want_tx, want_rx};
    assign off_pend = cur_q & ~want;
    assign on_pend  = want & ~cur_q;

`ifdef RCC_ETH_LP_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    // Compare one bit wider so tmo_cnt_q = 255 cannot alias onto drain_tmo = 0.
    assign tmo_hit = (drain_tmo != 8'd0) && (({1'b0, tmo_cnt_q} + 9'd1) == {1'b0, drain_tmo});
`else
    logic unused_tmo_inputs;
    assign unused_tmo_inputs = ^{drain_tmo, tmo_clr};
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cur_q      <= 2'b00;
            idle_cnt_q <= 2'd0;
            wake_cnt_q <= 4'd0;
            busy_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
`ifdef RCC_ETH_LP_TIMEOUT_EN
            tmo_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            busy_q     <= busy_d;
            tmo_flag_q <= tmo_flag_d;
`ifdef RCC_ETH_LP_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        tmo_set    = 1'b0;
`ifdef RCC_ETH_LP_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        case (state_q)
            RUN: begin
                // Turn-offs win over turn-ons; the turn-on is picked up after the drain.
                if (off_pend != 2'b00) begin
                    state_d    = DRAIN;
                    idle_cnt_d = 2'd0;
`ifdef RCC_ETH_LP_TIMEOUT_EN
                    tmo_cnt_d  = 8'd0;
`endif
                end else if (on_pend != 2'b00) begin
                    state_d    = WAKE;
                    wake_cnt_d = WAKE_INIT;
                end
            end
            DRAIN: begin
                if (off_pend == 2'b00) begin
                    state_d = RUN;
                end else if (eth_rcc_idle && idle_cnt_q == 2'd1) begin
                    cur_d   = cur_q & want;
                    state_d = RUN;
                end else if (tmo_hit) begin
                    cur_d   = cur_q & want;
                    tmo_set = 1'b1;
                    state_d = RUN;
                end else begin
                    idle_cnt_d = eth_rcc_idle ? idle_cnt_q + 2'd1 : 2'd0;
`ifdef RCC_ETH_LP_TIMEOUT_EN
                    tmo_cnt_d  = tmo_cnt_q + 8'd1;
`endif
                end
            end
            WAKE: begin
                if (on_pend == 2'b00) begin
                    state_d = RUN;
                end else if (wake_cnt_q == 4'd1) begin
                    cur_d   = cur_q | want;
                    state_d = RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        busy_d = (state_d != RUN);
`ifdef RCC_ETH_LP_TIMEOUT_EN
        tmo_flag_d = tmo_set | (tmo_flag_q & ~tmo_clr);
`else
        tmo_flag_d = 1'b0;
`endif
        rcc_eth1rx_clk_en = cur_q[0];
        rcc_eth1tx_clk_en = cur_q[1];
        rcc_eth_lp_busy   = busy_q;
        rcc_eth_tmo_flag  = tmo_flag_q;
    end

endmodule

// File: tb/tb_rcc_eth_lp_seq.sv
// Bench for rcc_eth_lp_seq: directed scenarios plus randomized traffic against a reference model.
module tb_rcc_eth_lp_seq;

    localparam int WAKE_DLY = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       c1_sleep, c1_deepsleep, c2_sleep, c2_deepsleep;
    logic       rcc_c1_eth1rx_en, rcc_c2_eth1rx_en, rcc_c1_eth1rx_lpen, rcc_c2_eth1rx_lpen;
    logic       rcc_c1_eth1tx_en, rcc_c2_eth1tx_en, rcc_c1_eth1tx_lpen, rcc_c2_eth1tx_lpen;
    logic       eth_rcc_idle;
    logic [7:0] drain_tmo;
    logic       tmo_clr;
    logic       rcc_eth1rx_clk_en, rcc_eth1tx_clk_en, rcc_eth_lp_busy, rcc_eth_tmo_flag;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = steady, 1 = draining, 2 = waking.
    int m_mode = 0;
    int m_idle_run = 0;
    int m_wake_left = 0;
    int m_drain_edges = 0;
    bit m_rx = 0, m_tx = 0, m_flag = 0;

`ifdef RCC_ETH_LP_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    rcc_eth_lp_seq #(.WAKE_DLY(WAKE_DLY)) dut (
        .clk(clk), .rst(rst),
        .c1_sleep(c1_sleep), .c1_deepsleep(c1_deepsleep),
        .c2_sleep(c2_sleep), .c2_deepsleep(c2_deepsleep),
        .rcc_c1_eth1rx_en(rcc_c1_eth1rx_en), .rcc_c2_eth1rx_en(rcc_c2_eth1rx_en),
        .rcc_c1_eth1rx_lpen(rcc_c1_eth1rx_lpen), .rcc_c2_eth1rx_lpen(rcc_c2_eth1rx_lpen),
        .rcc_c1_eth1tx_en(rcc_c1_eth1tx_en), .rcc_c2_eth1tx_en(rcc_c2_eth1tx_en),
        .rcc_c1_eth1tx_lpen(rcc_c1_eth1tx_lpen), .rcc_c2_eth1tx_lpen(rcc_c2_eth1tx_lpen),
        .eth_rcc_idle(eth_rcc_idle), .drain_tmo(drain_tmo), .tmo_clr(tmo_clr),
        .rcc_eth1rx_clk_en(rcc_eth1rx_clk_en), .rcc_eth1tx_clk_en(rcc_eth1tx_clk_en),
        .rcc_eth_lp_busy(rcc_eth_lp_busy), .rcc_eth_tmo_flag(rcc_eth_tmo_flag)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit core_wants(bit en, bit slp, bit lpen, bit dslp);
        if (!en || dslp) return 1'b0;
        return !slp || lpen;
    endfunction

    task automatic model_edge();
        bit w_rx, w_tx, turn_off, turn_on, set_flag;
        w_rx = core_wants(rcc_c1_eth1rx_en, c1_sleep, rcc_c1_eth1rx_lpen, c1_deepsleep)
             | core_wants(rcc_c2_eth1rx_en, c2_sleep, rcc_c2_eth1rx_lpen, c2_deepsleep);
        w_tx = core_wants(rcc_c1_eth1tx_en, c1_sleep, rcc_c1_eth1tx_lpen, c1_deepsleep)
             | core_wants(rcc_c2_eth1tx_en, c2_sleep, rcc_c2_eth1tx_lpen, c2_deepsleep);
        turn_off = (m_rx && !w_rx) || (m_tx && !w_tx);
        turn_on  = (!m_rx && w_rx) || (!m_tx && w_tx);
        set_flag = 1'b0;
        if (rst) begin
            m_mode = 0; m_rx = 0; m_tx = 0; m_flag = 0;
            m_idle_run = 0; m_wake_left = 0; m_drain_edges = 0;
            return;
        end
        if (m_mode == 0) begin
            if (turn_off) begin
                m_mode = 1; m_idle_run = 0; m_drain_edges = 0;
            end else if (turn_on) begin
                m_mode = 2; m_wake_left = WAKE_DLY;
            end
        end else if (m_mode == 1) begin
            if (!turn_off) m_mode = 0;
            else if (eth_rcc_idle && m_idle_run == 1) begin
                m_rx = m_rx & w_rx; m_tx = m_tx & w_tx; m_mode = 0;
            end else if (TMO_EN && drain_tmo != 0 && m_drain_edges + 1 == int'(drain_tmo)) begin
                m_rx = m_rx & w_rx; m_tx = m_tx & w_tx; m_mode = 0; set_flag = 1'b1;
            end else begin
                m_idle_run = eth_rcc_idle ? m_idle_run + 1 : 0;
                m_drain_edges++;
            end
        end else begin
            if (!turn_on) m_mode = 0;
            else if (m_wake_left == 1) begin
                m_rx = m_rx | w_rx; m_tx = m_tx | w_tx; m_mode = 0;
            end else m_wake_left--;
        end
        if (set_flag) m_flag = 1'b1;
        else if (TMO_EN && tmo_clr) m_flag = 1'b0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("model_rx", 8'(rcc_eth1rx_clk_en), 8'(m_rx));
        chk("model_tx", 8'(rcc_eth1tx_clk_en), 8'(m_tx));
        chk("model_busy", 8'(rcc_eth_lp_busy), 8'(m_mode != 0));
        chk("model_flag", 8'(rcc_eth_tmo_flag), 8'(m_flag));
    endtask

    task automatic clear_inputs();
        c1_sleep = 0; c1_deepsleep = 0; c2_sleep = 0; c2_deepsleep = 0;
        rcc_c1_eth1rx_en = 0; rcc_c2_eth1rx_en = 0; rcc_c1_eth1rx_lpen = 0; rcc_c2_eth1rx_lpen = 0;
        rcc_c1_eth1tx_en = 0; rcc_c2_eth1tx_en = 0; rcc_c1_eth1tx_lpen = 0; rcc_c2_eth1tx_lpen = 0;
        eth_rcc_idle = 0; drain_tmo = 8'd0; tmo_clr = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick(); tick();
        chk("reset_rx", 8'(rcc_eth1rx_clk_en), 8'd0);
        chk("reset_tx", 8'(rcc_eth1tx_clk_en), 8'd0);
        chk("reset_busy", 8'(rcc_eth_lp_busy), 8'd0);
        chk("reset_flag", 8'(rcc_eth_tmo_flag), 8'd0);
        rst = 0;

        // Wake: enable rises on edge WAKE_DLY+1, busy for WAKE_DLY cycles.
        rcc_c1_eth1rx_en = 1;
        for (int i = 1; i <= WAKE_DLY; i++) begin
            tick();
            chk("wake_rx_low", 8'(rcc_eth1rx_clk_en), 8'd0);
            chk("wake_busy", 8'(rcc_eth_lp_busy), 8'd1);
        end
        tick();
        chk("wake_rx_rise", 8'(rcc_eth1rx_clk_en), 8'd1);
        chk("wake_busy_end", 8'(rcc_eth_lp_busy), 8'd0);

        // Drain with idle held high: falls on the third edge.
        c1_deepsleep = 1; eth_rcc_idle = 1;
        tick(); chk("drain_e1", 8'(rcc_eth1rx_clk_en), 8'd1);
        chk("drain_busy", 8'(rcc_eth_lp_busy), 8'd1);
        tick(); chk("drain_e2", 8'(rcc_eth1rx_clk_en), 8'd1);
        tick(); chk("drain_e3", 8'(rcc_eth1rx_clk_en), 8'd0);
        chk("drain_done_busy", 8'(rcc_eth_lp_busy), 8'd0);

        // Re-enable, then drain with idle toggling: no gating until idle is held.
        c1_deepsleep = 0; eth_rcc_idle = 0;
        repeat (WAKE_DLY + 1) tick();
        chk("rewake_rx", 8'(rcc_eth1rx_clk_en), 8'd1);
        c1_deepsleep = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            eth_rcc_idle = (i % 2 == 0);
            tick();
            chk("toggle_hold", 8'(rcc_eth1rx_clk_en), 8'd1);
        end
        eth_rcc_idle = 1;
        tick(); chk("toggle_idle1", 8'(rcc_eth1rx_clk_en), 8'd1);
        tick(); chk("toggle_gate", 8'(rcc_eth1rx_clk_en), 8'd0);

        // TX with lpen survives sleep; a withdrawn RX drain never drops RX.
        c1_deepsleep = 0; eth_rcc_idle = 0;
        rcc_c1_eth1tx_en = 1; rcc_c1_eth1tx_lpen = 1;
        repeat (WAKE_DLY + 1) tick();
        chk("both_on_rx", 8'(rcc_eth1rx_clk_en), 8'd1);
        chk("both_on_tx", 8'(rcc_eth1tx_clk_en), 8'd1);
        c1_sleep = 1;
        tick(); tick();
        chk("sleep_tx", 8'(rcc_eth1tx_clk_en), 8'd1);
        chk("sleep_rx_held", 8'(rcc_eth1rx_clk_en), 8'd1);
        chk("sleep_busy", 8'(rcc_eth_lp_busy), 8'd1);
        c1_sleep = 0;
        tick();
        chk("abort_rx", 8'(rcc_eth1rx_clk_en), 8'd1);
        chk("abort_busy", 8'(rcc_eth_lp_busy), 8'd0);

        // Randomized traffic against the model.
        for (int blk = 0; blk < 120; blk++) begin
            c1_sleep = 1'($urandom_range(0, 3) == 0); c1_deepsleep = 1'($urandom_range(0, 5) == 0);
            c2_sleep = 1'($urandom_range(0, 3) == 0); c2_deepsleep = 1'($urandom_range(0, 5) == 0);
            rcc_c1_eth1rx_en = 1'($urandom); rcc_c2_eth1rx_en = 1'($urandom);
            rcc_c1_eth1rx_lpen = 1'($urandom); rcc_c2_eth1rx_lpen = 1'($urandom);
            rcc_c1_eth1tx_en = 1'($urandom); rcc_c2_eth1tx_en = 1'($urandom);
            rcc_c1_eth1tx_lpen = 1'($urandom); rcc_c2_eth1tx_lpen = 1'($urandom);
            drain_tmo = 8'($urandom_range(0, 12));
            for (int c = 0; c < int'($urandom_range(1, 10)); c++) begin
                eth_rcc_idle = 1'($urandom_range(0, 3) != 0);
                tmo_clr = 1'($urandom_range(0, 7) == 0);
                rst = 1'($urandom_range(0, 80) == 0);
                tick();
            end
        end
        rst = 0;

        // Reset mid-wake at wake_cnt = 2 aborts; the following wake takes the full delay.
        clear_inputs();
        rst = 1; tick(); rst = 0;
        rcc_c1_eth1rx_en = 1; rcc_c1_eth1tx_en = 1;
        tick(); tick(); tick();
        chk("midwake_busy", 8'(rcc_eth_lp_busy), 8'd1);
        rst = 1; tick(); rst = 0;
        chk("rstwake_rx", 8'(rcc_eth1rx_clk_en), 8'd0);
        chk("rstwake_tx", 8'(rcc_eth1tx_clk_en), 8'd0);
        chk("rstwake_busy", 8'(rcc_eth_lp_busy), 8'd0);
        for (int i = 1; i <= WAKE_DLY; i++) begin
            tick();
            chk("rewake_no_pulse", 8'({rcc_eth1tx_clk_en, rcc_eth1rx_clk_en}), 8'd0);
        end
        tick();
        chk("rewake_both", 8'({rcc_eth1tx_clk_en, rcc_eth1rx_clk_en}), 8'd3);

        // Drain with the MAC never idle: timeout build gates on the 8th drain edge.
        rcc_c1_eth1tx_en = 0; eth_rcc_idle = 0; drain_tmo = 8'd8; c1_deepsleep = 1;
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("tmo_hold", 8'(rcc_eth1rx_clk_en), 8'd1);
        end
        tick();
`ifdef RCC_ETH_LP_TIMEOUT_EN
        chk("tmo_gate", 8'(rcc_eth1rx_clk_en), 8'd0);
        chk("tmo_flag_set", 8'(rcc_eth_tmo_flag), 8'd1);
        tmo_clr = 1; tick(); tmo_clr = 0;
        chk("tmo_flag_clr", 8'(rcc_eth_tmo_flag), 8'd0);
`else
        repeat (12) tick();
        chk("no_tmo_hold", 8'(rcc_eth1rx_clk_en), 8'd1);
        chk("no_tmo_flag", 8'(rcc_eth_tmo_flag), 8'd0);
        eth_rcc_idle = 1; tick(); tick(); tick();
        chk("no_tmo_idle_gate", 8'(rcc_eth1rx_clk_en), 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
